// File: rtl/cpu_branch_pkg.sv
// Shared definitions for the branch/PC unit: branch type codes, FSM states and default width.
package cpu_branch_pkg;

    localparam int unsigned WORD_SIZE_DEF = 32;

    typedef enum logic [2:0] {
        BR_NONE = 3'b000,
        BR_BEQ  = 3'b001,
        BR_BNE  = 3'b010,
        BR_BLT  = 3'b011,
        BR_BLE  = 3'b100,
        BR_J    = 3'b101
    } br_type_e;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCompare = 2'd1,
        StResolve = 2'd2,
        StDone    = 2'd3
    } br_state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition: maps a branch type and two operands to a taken flag.
module branch_cond_eval
    import cpu_branch_pkg::*;
#(
    parameter int unsigned WORD_SIZE = WORD_SIZE_DEF
) (
    input  logic [2:0]           br_type,
    input  logic [WORD_SIZE-1:0] op_a,
    input  logic [WORD_SIZE-1:0] op_b,
    output logic                 taken
);

    always_comb begin
        taken = 1'b0;
        case (br_type_e'(br_type))
            BR_BEQ:  taken = (op_a == op_b);
            BR_BNE:  taken = (op_a != op_b);
            BR_BLT:  taken = ($signed(op_a) < $signed(op_b));
            BR_BLE:  taken = ($signed(op_a) <= $signed(op_b));
            BR_J:    taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_pc_unit.sv
// Branch condition / next-PC unit with a fixed 3-cycle request-to-done handshake.
// Optional saturating statistics counters are enabled by defining BR_STATS_EN.
module branch_pc_unit
    import cpu_branch_pkg::*;
#(
    parameter int unsigned WORD_SIZE = WORD_SIZE_DEF
`ifdef BR_STATS_EN
    ,
    parameter int unsigned BR_CNT_W = 16
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 br_req,
    input  logic [2:0]           br_type,
    input  logic [WORD_SIZE-1:0] reg_a,
    input  logic [WORD_SIZE-1:0] reg_b,
    input  logic [WORD_SIZE-1:0] pc_plus4,
    input  logic [WORD_SIZE-1:0] br_offset,
    output logic                 br_busy,
    output logic                 br_done,
    output logic                 br_taken,
    output logic [WORD_SIZE-1:0] pc_target,
    output logic                 pc_write
`ifdef BR_STATS_EN
    ,
    output logic [BR_CNT_W-1:0]  br_taken_cnt,
    output logic [BR_CNT_W-1:0]  br_total_cnt
`endif
);

    br_state_e            state_q, state_d;
    logic [2:0]           type_q, type_d;
    logic [WORD_SIZE-1:0] a_q, a_d;
    logic [WORD_SIZE-1:0] b_q, b_d;
    logic [WORD_SIZE-1:0] pc4_q, pc4_d;
    logic [WORD_SIZE-1:0] off_q, off_d;
    logic                 cond_q, cond_d;
    logic                 taken_q, taken_d;
    logic [WORD_SIZE-1:0] target_q, target_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 cond_now;
    logic [WORD_SIZE-1:0] branch_pc;
`ifdef BR_STATS_EN
    logic [BR_CNT_W-1:0]  taken_cnt_q, taken_cnt_d;
    logic [BR_CNT_W-1:0]  total_cnt_q, total_cnt_d;
`endif

    branch_cond_eval #(
        .WORD_SIZE (WORD_SIZE)
    ) u_cond_eval (
        .br_type (type_q),
        .op_a    (a_q),
        .op_b    (b_q),
        .taken   (cond_now)
    );

    // Shift drops the offset's top two bits; the add wraps modulo 2^WORD_SIZE.
    assign branch_pc = pc4_q + (off_q << 2);

    always_comb begin
        state_d  = state_q;
        type_d   = type_q;
        a_d      = a_q;
        b_d      = b_q;
        pc4_d    = pc4_q;
        off_d    = off_q;
        cond_d   = cond_q;
        taken_d  = taken_q;
        target_d = target_q;
        done_d   = 1'b0;
        busy_d   = busy_q;
`ifdef BR_STATS_EN
        taken_cnt_d = taken_cnt_q;
        total_cnt_d = total_cnt_q;
`endif
        case (state_q)
            StIdle: begin
                if (br_req) begin
                    type_d  = br_type;
                    a_d     = reg_a;
                    b_d     = reg_b;
                    pc4_d   = pc_plus4;
                    off_d   = br_offset;
                    busy_d  = 1'b1;
                    state_d = StCompare;
                end
            end
            StCompare: begin
                cond_d  = cond_now;
                state_d = StResolve;
            end
            StResolve: begin
                // Visible results change only together with the done pulse.
                taken_d  = cond_q;
                target_d = cond_q ? branch_pc : pc4_q;
                done_d   = 1'b1;
                state_d  = StDone;
`ifdef BR_STATS_EN
                if (total_cnt_q != {BR_CNT_W{1'b1}}) begin
                    total_cnt_d = total_cnt_q + BR_CNT_W'(1);
                end
                if (cond_q && (taken_cnt_q != {BR_CNT_W{1'b1}})) begin
                    taken_cnt_d = taken_cnt_q + BR_CNT_W'(1);
                end
`endif
            end
            StDone: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            type_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            pc4_q    <= '0;
            off_q    <= '0;
            cond_q   <= 1'b0;
            taken_q  <= 1'b0;
            target_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef BR_STATS_EN
            taken_cnt_q <= '0;
            total_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            type_q   <= type_d;
            a_q      <= a_d;
            b_q      <= b_d;
            pc4_q    <= pc4_d;
            off_q    <= off_d;
            cond_q   <= cond_d;
            taken_q  <= taken_d;
            target_q <= target_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
`ifdef BR_STATS_EN
            taken_cnt_q <= taken_cnt_d;
            total_cnt_q <= total_cnt_d;
`endif
        end
    end

    assign br_busy   = busy_q;
    assign br_done   = done_q;
    assign pc_write  = done_q;
    assign br_taken  = taken_q;
    assign pc_target = target_q;
`ifdef BR_STATS_EN
    assign br_taken_cnt = taken_cnt_q;
    assign br_total_cnt = total_cnt_q;
`endif

endmodule
